// File: rtl/mont_redc_serial.sv
// Serial radix-2 Montgomery reduction: oR = iT * 2^-wI mod iM, nSTEP bits retired per clock.
// Optional macro MONT_REDC_ERR_EN adds o_err and the illegal-operand check.
module mont_redc_serial #(
    parameter int wI    = 1024,
    parameter int nSTEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [2*wI-1:0]   iT,
    input  logic [wI-1:0]     iM,
    output logic              o_ready,
    output logic              o_finish,
    output logic [wI-1:0]     oR
`ifdef MONT_REDC_ERR_EN
    ,
    output logic              o_err
`endif
);

    localparam int N  = wI / nSTEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if ((wI % nSTEP) != 0) begin : g_bad_step
        $error("mont_redc_serial: wI must be a multiple of nSTEP");
    end

    // Handshake: i_valid is sampled only while o_ready is high (IDLE); a
    // sampled i_valid starts one reduction, which ends in a one-cycle o_finish.
    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        FINAL
    } state_t;

    state_t          r_state;
    logic [2*wI:0]   r_acc;
    logic [wI-1:0]   r_m;
    logic [CW-1:0]   r_cnt;
    logic [2*wI:0]   w_acc_next;
    logic [2*wI:0]   w_m_ext;
    logic [wI-1:0]   w_sub;
    logic [wI-1:0]   w_res;
    logic            w_ge;
`ifdef MONT_REDC_ERR_EN
    logic            r_err;
    logic            w_err_in;

    // T >= M*R is the same as the upper half of T reaching M.
    assign w_err_in = ~iM[0] | (iT[2*wI-1:wI] >= iM);
`endif

    assign w_m_ext = {{(wI+1){1'b0}}, r_m};

    always_comb begin
        w_acc_next = r_acc;
        for (int i = 0; i < nSTEP; i++) begin
            if (w_acc_next[0]) begin
                w_acc_next = w_acc_next + w_m_ext;
            end
            w_acc_next = w_acc_next >> 1;
        end
    end

    // acc < 2M after the loop, so the low wI bits of acc - M are exact.
    assign w_ge    = (r_acc >= w_m_ext);
    assign w_sub   = r_acc[wI-1:0] - r_m;
    assign w_res   = w_ge ? w_sub : r_acc[wI-1:0];
    assign o_ready = (r_state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_m      <= '0;
            r_cnt    <= '0;
            oR       <= '0;
            o_finish <= 1'b0;
`ifdef MONT_REDC_ERR_EN
            r_err    <= 1'b0;
            o_err    <= 1'b0;
`endif
        end else begin
            o_finish <= 1'b0;
`ifdef MONT_REDC_ERR_EN
            o_err    <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_acc   <= {1'b0, iT};
                        r_m     <= iM;
                        r_cnt   <= '0;
                        r_state <= REDUCE;
`ifdef MONT_REDC_ERR_EN
                        r_err   <= w_err_in;
`endif
                    end
                end
                REDUCE: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N - 1)) begin
                        r_state <= FINAL;
                    end
                end
                FINAL: begin
`ifdef MONT_REDC_ERR_EN
                    oR    <= r_err ? '0 : w_res;
                    o_err <= r_err;
`else
                    oR    <= w_res;
`endif
                    o_finish <= 1'b1;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mont_redc_serial.md
Name: mont_redc_serial

Overview:
- Downstream consumer of the Karatsuba multiplier `karat_mult_recursion`.
- Accepts its 2*wI-bit product T together with an odd modulus M.
- Computes the Montgomery reduction T * 2^(-wI) mod M using an iterative radix-2 shift-add loop, nSTEP bits per cycle.
- Hands the wI-bit residue on to the MSM point-arithmetic datapath with a single-cycle finish pulse.

Parameters:
- wI, 1024: operand and modulus width; R = 2^wI.
- nSTEP, 1: reduction bits retired per clock. wI % nSTEP == 0 is required; elaboration fails otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input strobe; connects to multiplier o_finish.
- iT  input  2*wI  product to reduce; requires T < M*R.
- iM  input  wI  odd modulus.
- o_ready  output  1  high while idle, meaning a new input can be accepted.
- o_finish  output  1  one-cycle pulse: oR valid.
- oR  output  wI  result T*R^-1 mod M; held until the next o_finish.
- o_err  output  1  only present with MONT_REDC_ERR_EN; see Optional Feature.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state = IDLE; accumulator, counter and captured M cleared.
  - oR = 0, o_finish = 0, o_err = 0, o_ready = 1.
  - The in-flight operation is discarded; no o_finish is produced for it.
- States: IDLE, REDUCE, FINAL. o_ready = (state == IDLE).
- IDLE:
  - On an edge with i_valid = 1, capture acc = {1'b0, iT} (2*wI+1 bits) and Mreg = iM.
  - Clear counter; go to REDUCE.
  - i_valid = 0 leaves the state in IDLE.
- REDUCE:
  - Each edge performs nSTEP unrolled radix-2 steps: if acc[0] then acc = acc + Mreg; then acc = acc >> 1.
  - The counter increments once per edge.
  - After N = wI/nSTEP edges, go to FINAL.
  - At that point acc < 2*Mreg and fits in wI+1 bits.
- FINAL (one edge):
  - oR = (acc >= Mreg) ? acc - Mreg : acc, truncated to wI bits.
  - o_finish = 1 for exactly one cycle; next state IDLE.
- Latency:
  - Accept edge at cycle 0; o_finish is high in the cycle following edge N+1.
  - Example: wI = 8, nSTEP = 1 gives o_finish 9 edges after accept.
- Back-to-back: o_ready is already 1 during the o_finish cycle. An i_valid in that cycle is accepted on the next edge, so throughput is one result per N+2 cycles.
- i_valid while not IDLE: ignored entirely. No capture, no state change, no error.
- iT / iM changes after accept have no effect, since the operands are registered.
- Arithmetic width: the accumulator is 2*wI+1 bits, so the adder never overflows for legal inputs.
- Illegal inputs (M even, or T >= M*R) without MONT_REDC_ERR_EN: oR is unspecified, but timing and handshake are unchanged.

Optional Feature:
- Macro: MONT_REDC_ERR_EN.
- Defined:
  - At accept, compute err = ~iM[0] | (iT[2*wI-1:wI] >= iM). The second term is equivalent to T >= M*R.
  - err is registered and reported on o_err during the o_finish cycle; in that case oR is forced to 0.
  - o_err is 0 in all other cycles.
  - Latency is unchanged.
- Undefined: the o_err port and the check logic are absent; behaviour is otherwise identical.

Test Plan:
- Basic reduction (wI = 8, nSTEP = 1, M = 13; R^-1 mod 13 = 3):
  - T = 1 -> oR = 3.
  - T = 256 -> oR = 1.
  - T = 0 -> oR = 0.
  - T = 3327 -> oR = 10.
  - Each case: o_finish exactly 9 edges after accept and high for 1 cycle.
- nSTEP = 4, wI = 8, M = 13, T = 3327 -> oR = 10, with o_finish 3 edges after accept. Repeat with wI = 1024, nSTEP = 8, using 2000 random odd M and T < M*R fed from karat_mult_recursion: oR == T*R^-1 mod M on every result.
- Handshake:
  - Pulse i_valid during REDUCE with different iT -> ignored; the result matches the first operand.
  - Assert i_valid in the o_finish cycle -> accepted; second o_finish arrives N+2 cycles after the first.
- Reset: assert rst_n = 0 at REDUCE counter = 4 -> immediately oR = 0, o_finish = 0, o_ready = 1. No stale o_finish after release; next op (T = 256) -> oR = 1.
- MONT_REDC_ERR_EN (wI = 8):
  - M = 12, T = 5 -> o_err = 1, oR = 0.
  - M = 13, T = 3328 -> o_err = 1.
  - M = 13, T = 3327 -> o_err = 0, oR = 10.
